// File: rtl/systolic_skew_feeder.sv
// Diagonal skew feeder for the systolic array edge: lane i lags lane 0 by i cycles.
// Optional SKEW_FEEDER_STALL_CNT_EN adds a saturating per-tile stall counter output.
module systolic_skew_feeder #(
  parameter int unsigned OPERAND_WIDTH = 8,
  parameter int unsigned ARRAY_DIM     = 4,
  parameter int unsigned K_WIDTH       = 8
) (
  input  logic                               clk_i,
  input  logic                               reset,
  input  logic                               start_i,
  input  logic [K_WIDTH-1:0]                 k_len_i,
  output logic                               busy_o,
  output logic                               done_o,
  input  logic                               in_valid_i,
  output logic                               in_ready_o,
  input  logic [ARRAY_DIM*OPERAND_WIDTH-1:0] in_data_i,
  output logic [ARRAY_DIM*OPERAND_WIDTH-1:0] out_data_o,
  output logic [ARRAY_DIM-1:0]               out_valid_o
`ifdef SKEW_FEEDER_STALL_CNT_EN
  ,
  output logic [15:0]                        stall_cnt_o
`endif
);

  localparam int unsigned FLUSH_W = $clog2(ARRAY_DIM);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FLUSH,
    DONE
  } state_t;

  state_t               state;
  logic [K_WIDTH-1:0]   k_len;
  logic [K_WIDTH-1:0]   beat_cnt;
  logic [FLUSH_W-1:0]   flush_cnt;
  logic                 accept;

  assign accept = in_valid_i & in_ready_o;

  // Tile sequencer; handshake/status outputs are registered alongside the state.
  always_ff @(posedge clk_i) begin
    if (reset) begin
      state      <= IDLE;
      k_len      <= '0;
      beat_cnt   <= '0;
      flush_cnt  <= '0;
      in_ready_o <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            k_len    <= k_len_i;
            beat_cnt <= '0;
            busy_o   <= 1'b1;
            if (k_len_i == '0) begin
              state  <= DONE;
              done_o <= 1'b1;
            end else begin
              state      <= STREAM;
              in_ready_o <= 1'b1;
            end
          end
        end
        STREAM: begin
          if (in_valid_i) begin
            beat_cnt <= beat_cnt + K_WIDTH'(1);
            if (beat_cnt == k_len - K_WIDTH'(1)) begin
              state      <= FLUSH;
              in_ready_o <= 1'b0;
              flush_cnt  <= '0;
            end
          end
        end
        FLUSH: begin
          if (flush_cnt == FLUSH_W'(ARRAY_DIM - 2)) begin
            state  <= DONE;
            done_o <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt + FLUSH_W'(1);
          end
        end
        DONE: begin
          state  <= IDLE;
          done_o <= 1'b0;
          busy_o <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          in_ready_o <= 1'b0;
          busy_o     <= 1'b0;
          done_o     <= 1'b0;
        end
      endcase
    end
  end

  // Per-lane delay line of depth i+1; non-accepted slots enter as zero/invalid.
  for (genvar i = 0; i < ARRAY_DIM; i++) begin : g_lane
    logic [OPERAND_WIDTH-1:0] dq [0:i];
    logic                     vq [0:i];

    always_ff @(posedge clk_i) begin
      if (reset) begin
        for (int j = 0; j <= i; j++) begin
          dq[j] <= '0;
          vq[j] <= 1'b0;
        end
      end else begin
        dq[0] <= accept ? in_data_i[i*OPERAND_WIDTH +: OPERAND_WIDTH] : '0;
        vq[0] <= accept;
        for (int j = 1; j <= i; j++) begin
          dq[j] <= dq[j-1];
          vq[j] <= vq[j-1];
        end
      end
    end

    assign out_data_o[i*OPERAND_WIDTH +: OPERAND_WIDTH] = dq[i];
    assign out_valid_o[i]                               = vq[i];
  end

`ifdef SKEW_FEEDER_STALL_CNT_EN
  // Counts STREAM cycles without upstream data; cleared by an accepted start.
  always_ff @(posedge clk_i) begin
    if (reset) begin
      stall_cnt_o <= '0;
    end else if (state == IDLE && start_i) begin
      stall_cnt_o <= '0;
    end else if (state == STREAM && !in_valid_i && stall_cnt_o != 16'hFFFF) begin
      stall_cnt_o <= stall_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder (ARRAY_DIM=4, OPERAND_WIDTH=8).
// Stall-counter checks are built only with SKEW_FEEDER_STALL_CNT_EN.
module tb_systolic_skew_feeder;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic [7:0]  k_len_i;
  logic        busy_o;
  logic        done_o;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] in_data_i;
  logic [31:0] out_data_o;
  logic [3:0]  out_valid_o;
`ifdef SKEW_FEEDER_STALL_CNT_EN
  logic [15:0] stall_cnt_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] vec [3];

  always #5 clk = ~clk;

  systolic_skew_feeder #(
    .OPERAND_WIDTH(8),
    .ARRAY_DIM    (4),
    .K_WIDTH      (8)
  ) dut (
    .clk_i      (clk),
    .reset      (reset),
    .start_i    (start_i),
    .k_len_i    (k_len_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_data_i  (in_data_i),
    .out_data_o (out_data_o),
    .out_valid_o(out_valid_o)
`ifdef SKEW_FEEDER_STALL_CNT_EN
    ,
    .stall_cnt_o(stall_cnt_o)
`endif
  );

  // Apply inputs just after an edge, then move to the mid-cycle sample point.
  task automatic drive(input logic s, input logic [7:0] k, input logic v, input logic [31:0] d);
    start_i    = s;
    k_len_i    = k;
    in_valid_i = v;
    in_data_i  = d;
    #4;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected {valid, data} on lane i in cycle c, given the acceptance cycles of the three beats.
  function automatic logic [8:0] exp_lane(input int i, input int c, input int a0, input int a1,
                                          input int a2);
    int          acc [3];
    logic [31:0] w;
    acc[0] = a0;
    acc[1] = a1;
    acc[2] = a2;
    for (int b = 0; b < 3; b++) begin
      if (acc[b] + 1 + i == c) begin
        w = vec[b];
        return {1'b1, w[i*8 +: 8]};
      end
    end
    return 9'h000;
  endfunction

  task automatic test_reset;
    reset = 1'b1;
    drive(1'b1, 8'd3, 1'b1, 32'hFFFF_FFFF);
    tick;
    tick;
    drive(1'b0, 8'd0, 1'b0, 32'h0);
    n_tests++;
    if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b exp 0", in_ready_o); end
    n_tests++;
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy_o); end
    n_tests++;
    if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done_o); end
    n_tests++;
    if (out_data_o !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h exp 0", out_data_o); end
    n_tests++;
    if (out_valid_o !== 4'h0) begin n_fail++; $display("FAIL reset_valid got %h exp 0", out_valid_o); end
    reset = 1'b0;
    tick;
    tick;
  endtask

  // Three-beat tile; optional bubble in cycle 2 and an ignored restart (k_len=9) in cycle 2.
  task automatic test_stream(input logic bubble, input logic restart);
    int          a0, a1, a2, last;
    logic        v, s, e_ready, e_busy, e_done;
    logic [7:0]  k;
    logic [31:0] d;
    logic [8:0]  got, exp;
    a0 = 1;
    a1 = bubble ? 3 : 2;
    a2 = bubble ? 4 : 3;
    last = a2;
    for (int c = 0; c <= last + 6; c++) begin
      v = (c == a0) || (c == a1) || (c == a2);
      d = 32'h0;
      if (c == a0) d = vec[0];
      if (c == a1) d = vec[1];
      if (c == a2) d = vec[2];
      s = (c == 0) || (restart && c == 2);
      k = (restart && c == 2) ? 8'd9 : 8'd3;
      drive(s, k, v, d);
      e_ready = (c >= 1) && (c <= last);
      e_busy  = (c >= 1) && (c <= last + 4);
      e_done  = (c == last + 4);
      n_tests++;
      if (in_ready_o !== e_ready) begin
        n_fail++; $display("FAIL stream_ready b=%0b r=%0b c=%0d got %b exp %b", bubble, restart, c, in_ready_o, e_ready);
      end
      n_tests++;
      if (busy_o !== e_busy) begin
        n_fail++; $display("FAIL stream_busy b=%0b r=%0b c=%0d got %b exp %b", bubble, restart, c, busy_o, e_busy);
      end
      n_tests++;
      if (done_o !== e_done) begin
        n_fail++; $display("FAIL stream_done b=%0b r=%0b c=%0d got %b exp %b", bubble, restart, c, done_o, e_done);
      end
      for (int i = 0; i < 4; i++) begin
        got = {out_valid_o[i], out_data_o[i*8 +: 8]};
        exp = exp_lane(i, c, a0, a1, a2);
        n_tests++;
        if (got !== exp) begin
          n_fail++; $display("FAIL stream_lane%0d b=%0b r=%0b c=%0d got %h exp %h", i, bubble, restart, c, got, exp);
        end
      end
      tick;
    end
  endtask

  task automatic test_zero_len;
    for (int c = 0; c <= 4; c++) begin
      drive(c == 0, 8'd0, 1'b1, 32'hDEAD_BEEF);
      n_tests++;
      if (done_o !== (c == 1)) begin n_fail++; $display("FAIL zero_done c=%0d got %b exp %b", c, done_o, c == 1); end
      n_tests++;
      if (busy_o !== (c == 1)) begin n_fail++; $display("FAIL zero_busy c=%0d got %b exp %b", c, busy_o, c == 1); end
      n_tests++;
      if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL zero_ready c=%0d got %b exp 0", c, in_ready_o); end
      n_tests++;
      if (out_valid_o !== 4'h0) begin n_fail++; $display("FAIL zero_valid c=%0d got %h exp 0", c, out_valid_o); end
      tick;
    end
    drive(1'b0, 8'd0, 1'b0, 32'h0);
    tick;
  endtask

  // Reset in cycle 3 aborts the first tile; a fresh tile starts in cycle 5 (beats in 6..8).
  task automatic test_reset_mid_tile;
    logic        v, e_ready, e_busy, e_done;
    logic [31:0] d;
    logic [8:0]  got, exp;
    for (int c = 0; c <= 14; c++) begin
      reset = (c == 3);
      v = ((c >= 1) && (c <= 3)) || ((c >= 6) && (c <= 8));
      d = 32'h0;
      if (c >= 1 && c <= 3) d = vec[c-1];
      if (c >= 6 && c <= 8) d = vec[c-6];
      drive((c == 0) || (c == 5), 8'd3, v, d);
      e_ready = ((c >= 1) && (c <= 3)) || ((c >= 6) && (c <= 8));
      e_busy  = ((c >= 1) && (c <= 3)) || ((c >= 6) && (c <= 12));
      e_done  = (c == 12);
      n_tests++;
      if (in_ready_o !== e_ready) begin n_fail++; $display("FAIL rst_ready c=%0d got %b exp %b", c, in_ready_o, e_ready); end
      n_tests++;
      if (busy_o !== e_busy) begin n_fail++; $display("FAIL rst_busy c=%0d got %b exp %b", c, busy_o, e_busy); end
      n_tests++;
      if (done_o !== e_done) begin n_fail++; $display("FAIL rst_done c=%0d got %b exp %b", c, done_o, e_done); end
      for (int i = 0; i < 4; i++) begin
        got = {out_valid_o[i], out_data_o[i*8 +: 8]};
        exp = (c <= 3) ? exp_lane(i, c, 1, 2, 3) : exp_lane(i, c, 6, 7, 8);
        n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL rst_lane%0d c=%0d got %h exp %h", i, c, got, exp); end
      end
      tick;
    end
    reset = 1'b0;
  endtask

`ifdef SKEW_FEEDER_STALL_CNT_EN
  task automatic test_stall_cnt;
    logic        v;
    logic [31:0] d;
    logic [15:0] e;
    for (int c = 0; c <= 10; c++) begin
      v = (c == 1) || (c == 3) || (c == 4);
      d = 32'h0;
      if (c == 1) d = vec[0];
      if (c == 3) d = vec[1];
      if (c == 4) d = vec[2];
      drive(c == 0, 8'd3, v, d);
      e = (c >= 3) ? 16'd1 : 16'd0;
      if (c >= 1) begin
        n_tests++;
        if (stall_cnt_o !== e) begin n_fail++; $display("FAIL stall_cnt c=%0d got %h exp %h", c, stall_cnt_o, e); end
      end
      tick;
    end
    drive(1'b1, 8'd1, 1'b0, 32'h0);
    tick;
    repeat (70000) @(posedge clk);
    #1;
    drive(1'b0, 8'd1, 1'b0, 32'h0);
    n_tests++;
    if (stall_cnt_o !== 16'hFFFF) begin n_fail++; $display("FAIL stall_sat got %h exp ffff", stall_cnt_o); end
    tick;
    drive(1'b0, 8'd1, 1'b1, 32'h1111_1111);
    tick;
    drive(1'b0, 8'd1, 1'b0, 32'h0);
    repeat (6) tick;
    n_tests++;
    if (stall_cnt_o !== 16'hFFFF) begin n_fail++; $display("FAIL stall_hold got %h exp ffff", stall_cnt_o); end
  endtask
`endif

  initial begin
    vec[0] = 32'h0403_0201;
    vec[1] = 32'h0807_0605;
    vec[2] = 32'h0C0B_0A09;
    reset      = 1'b1;
    start_i    = 1'b0;
    k_len_i    = 8'd0;
    in_valid_i = 1'b0;
    in_data_i  = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    test_stream(1'b0, 1'b0);
    test_stream(1'b1, 1'b0);
    test_zero_len;
    test_stream(1'b0, 1'b1);
    test_reset_mid_tile;
`ifdef SKEW_FEEDER_STALL_CNT_EN
    test_stall_cnt;
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
